// File: rtl/breg_loader.sv
// Byte-stream register-bank loader: packs MSB-first bytes into 32-bit words
// and writes them to ascending addresses 0..NREG-1, one write cycle per word.
module breg_loader #(
  parameter int NREG = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Start,
  input  logic [7:0]  ByteIn,
  input  logic        ByteValid,
  output logic        ByteReady,
  output logic [4:0]  AW,
  output logic [31:0] Di,
  output logic        RegWrite,
  output logic        Busy,
  output logic        Done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'(NREG - 1);

  state_t      state_q;
  logic [1:0]  byte_cnt_q;
  logic [4:0]  idx_q;
  logic [31:0] word_q;
  logic [4:0]  aw_q;
  logic [31:0] di_q;
  logic        regwrite_q;
  logic        ready_q;
  logic        busy_q;
  logic        done_q;

  logic [31:0] word_d;
  logic        accept_d;

  // The 4th byte goes straight into Di so the write strobe rises on that same edge.
  always_comb begin
    word_d   = {word_q[23:0], ByteIn};
    accept_d = ready_q & ByteValid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= 2'd0;
      idx_q      <= 5'd0;
      word_q     <= 32'd0;
      aw_q       <= 5'd0;
      di_q       <= 32'd0;
      regwrite_q <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      regwrite_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            state_q    <= S_RECV;
            byte_cnt_q <= 2'd0;
            idx_q      <= 5'd0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        S_RECV: begin
          if (accept_d) begin
            word_q     <= word_d;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              state_q    <= S_WRITE;
              ready_q    <= 1'b0;
              regwrite_q <= 1'b1;
              aw_q       <= idx_q;
              di_q       <= word_d;
            end
          end
        end
        S_WRITE: begin
          if (idx_q == LAST_IDX) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_RECV;
            idx_q   <= idx_q + 5'd1;
            ready_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (Start) begin
            state_q    <= S_RECV;
            byte_cnt_q <= 2'd0;
            idx_q      <= 5'd0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ByteReady = ready_q;
  assign AW        = aw_q;
  assign Di        = di_q;
  assign RegWrite  = regwrite_q;
  assign Busy      = busy_q;
  assign Done      = done_q;

endmodule
